// File: rtl/knight_move_seq.sv
// Knight move sequencer: turns a move index into two leg commands for RemoteComm,
// waits for each acknowledge, tracks the board position and latches errors.
module knight_move_seq #(
  parameter logic [2:0]  START_X = 3'd1,
  parameter logic [2:0]  START_Y = 3'd1,
  parameter logic [25:0] TMO_CYC = 26'd50_000_000,
  parameter logic [7:0]  POS_ACK = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cal_req,
  input  logic        mv_vld,
  input  logic [2:0]  mv_idx,
  output logic        mv_rdy,
  output logic [15:0] cmd,
  output logic        snd_cmd,
  input  logic        cmd_snt,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        cal_ok,
  output logic [2:0]  xx,
  output logic [2:0]  yy,
  output logic        mv_done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [15:0] CalGyro = 16'h2000;

  typedef enum logic [2:0] {StIdle, StSend, StWaitSnt, StWaitResp, StErr} state_e;

  state_e      state_q, state_d;
  logic        leg_q, leg_d;
  logic        cal_q, cal_d;
  logic [2:0]  mv_q, mv_d;
  logic [2:0]  dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [15:0] cmd_q, cmd_d;
  logic        snd_q, snd_d;
  logic        done_q, done_d;
  logic        cal_ok_q, cal_ok_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [2:0]  xx_q, xx_d, yy_q, yy_d;
  logic [25:0] cnt_q, cnt_d;

  logic signed [8:0] dx, dy, nx, ny;
  logic              off_board, tmo;

  // Leg 0 is the vertical leg, leg 1 the horizontal one; idx[2] selects the 1/2 split.
  function automatic logic [15:0] leg_cmd(input logic [2:0] idx, input logic horiz);
    if (!horiz) begin
      leg_cmd = {4'h4, (idx[1] ? 8'h7F : 8'h00), (idx[2] ? 4'd1 : 4'd2)};
    end else begin
      leg_cmd = {4'h5, (idx[0] ? 8'h3F : 8'hBF), (idx[2] ? 4'd2 : 4'd1)};
    end
  endfunction

  // Candidate destination of the offered move and its board check.
  always_comb begin
    dx = mv_idx[2] ? 9'sd2 : 9'sd1;
    dy = mv_idx[2] ? 9'sd1 : 9'sd2;
    if (mv_idx[0]) dx = -dx;
    if (mv_idx[1]) dy = -dy;
    nx = $signed({6'b0, xx_q}) + dx;
    ny = $signed({6'b0, yy_q}) + dy;
    off_board = (nx < 9'sd0) || (nx > 9'sd4) || (ny < 9'sd0) || (ny > 9'sd4);
  end

  assign tmo = (cnt_q == TMO_CYC - 26'd1);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    leg_d    = leg_q;
    cal_d    = cal_q;
    mv_d     = mv_q;
    dst_x_d  = dst_x_q;
    dst_y_d  = dst_y_q;
    cmd_d    = cmd_q;
    snd_d    = 1'b0;
    done_d   = 1'b0;
    cal_ok_d = cal_ok_q;
    err_d    = err_q;
    code_d   = code_q;
    xx_d     = xx_q;
    yy_d     = yy_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cal_req) begin
          cmd_d   = CalGyro;
          cal_d   = 1'b1;
          state_d = StSend;
        end else if (mv_vld && mv_rdy) begin
          if (off_board) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = StErr;
          end else begin
            mv_d    = mv_idx;
            dst_x_d = nx[2:0];
            dst_y_d = ny[2:0];
            leg_d   = 1'b0;
            cal_d   = 1'b0;
            cmd_d   = leg_cmd(mv_idx, 1'b0);
            state_d = StSend;
          end
        end
      end
      StSend: begin
        snd_d   = 1'b1;
        cnt_d   = '0;
        state_d = StWaitSnt;
      end
      StWaitSnt: begin
        cnt_d = cnt_q + 26'd1;
        if (tmo) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = StErr;
        end else if (cmd_snt) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        cnt_d = cnt_q + 26'd1;
        // A response arriving on the terminal count still wins over the timeout.
        if (resp_rdy) begin
          if (resp == POS_ACK) begin
            if (cal_q) begin
              cal_ok_d = 1'b1;
              state_d  = StIdle;
            end else if (!leg_q) begin
              yy_d    = dst_y_q;
              leg_d   = 1'b1;
              cmd_d   = leg_cmd(mv_q, 1'b1);
              state_d = StSend;
            end else begin
              xx_d    = dst_x_q;
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = StErr;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = StErr;
        end
      end
      StErr: state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      leg_q    <= 1'b0;
      cal_q    <= 1'b0;
      mv_q     <= '0;
      dst_x_q  <= START_X;
      dst_y_q  <= START_Y;
      cmd_q    <= '0;
      snd_q    <= 1'b0;
      done_q   <= 1'b0;
      cal_ok_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      xx_q     <= START_X;
      yy_q     <= START_Y;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      leg_q    <= leg_d;
      cal_q    <= cal_d;
      mv_q     <= mv_d;
      dst_x_q  <= dst_x_d;
      dst_y_q  <= dst_y_d;
      cmd_q    <= cmd_d;
      snd_q    <= snd_d;
      done_q   <= done_d;
      cal_ok_q <= cal_ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      xx_q     <= xx_d;
      yy_q     <= yy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mv_rdy   = (state_q == StIdle) && cal_ok_q && !err_q;
  assign cmd      = cmd_q;
  assign snd_cmd  = snd_q;
  assign cal_ok   = cal_ok_q;
  assign xx       = xx_q;
  assign yy       = yy_q;
  assign mv_done  = done_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule
